// File: rtl/digit_bus_encoder.sv
// digit_bus_encoder: producer side of the 6-bit digit bus for an 8-digit display.
// Converts binary hours/minutes/seconds to BCD with a sequential double-dabble
// engine (6 shifts per field, 18 cycles total), then commits all six digits at once.
// Blink phase toggles on every pulse_500ms and drives the colon dots and edit blink.
// Digit code: d[5]=enable, d[4:1]=value, d[0]=decimal point.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   load                1-cycle capture request (ignored unless idle)
//   hours/minutes/seconds  binary time fields
//   edit_field          0=none, 1=hours, 2=minutes, 3=seconds (blinked)
//   pulse_500ms         blink phase toggle strobe
//   busy, done          conversion in progress / 1-cycle commit pulse
//   d1..d8              digit codes; d6d5=HH, d4d3=MM, d2d1=SS, d8/d7 blank
//
// Optional feature: define DIGIT_RANGE_CHECK_EN to show out-of-range fields
// (above HOURS_MAX / MINSEC_MAX) as "EE".

module digit_bus_encoder #(
    parameter int unsigned HOURS_MAX  = 23,
    parameter int unsigned MINSEC_MAX = 59
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] edit_field,
    input  logic       pulse_500ms,
    output logic       busy,
    output logic       done,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8
);

    localparam int unsigned BIN_W   = 6;
    localparam int unsigned BCD_W   = 8;
    localparam int unsigned SH_W    = BCD_W + BIN_W;
    localparam int unsigned DIGIT_W = 6;
    localparam int unsigned NDIG    = 6;
    localparam int unsigned DISP_W  = 4 * NDIG;

    localparam logic [2:0]         LAST_BIT  = 3'd5;
    localparam logic [DIGIT_W-1:0] DIG_RESET = 6'b100000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_e;

    state_e                        state_q, state_d;
    logic [2:0]                    bit_q, bit_d;
    logic [1:0]                    fld_q, fld_d;
    logic [SH_W-1:0]               sh_q, sh_d;
    logic [BIN_W-1:0]              min_q, min_d;
    logic [BIN_W-1:0]              sec_q, sec_d;
    logic [1:0]                    edit_cap_q, edit_cap_d;
    logic [BCD_W-1:0]              bcd_h_q, bcd_h_d;
    logic [BCD_W-1:0]              bcd_m_q, bcd_m_d;
    logic [DISP_W-1:0]             disp_q, disp_d;
    logic [1:0]                    edit_disp_q, edit_disp_d;
    logic                          phase_q, phase_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [NDIG-1:0][DIGIT_W-1:0]  dig_q, dig_d;
    logic [2:0]                    err_q, err_d;
    logic [2:0]                    err_cap_c;
    logic [SH_W-1:0]               sh_step_c;
    logic                          en_h_c, en_m_c, en_s_c;

    // Out-of-range flags per field, {hours, minutes, seconds}
`ifdef DIGIT_RANGE_CHECK_EN
    assign err_cap_c = {32'(hours) > HOURS_MAX,
                        32'(minutes) > MINSEC_MAX,
                        32'(seconds) > MINSEC_MAX};
`else
    logic unused_params;
    assign unused_params = ^{HOURS_MAX, MINSEC_MAX};
    assign err_cap_c     = 3'b000;
`endif

    // One double-dabble step: add 3 to BCD nibbles >= 5, then shift left
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
        logic [3:0] t;
        logic [3:0] o;
        t = s[13:10];
        o = s[9:6];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t[2:0], o, s[5:0], 1'b0};
    endfunction

    assign sh_step_c = dd_step(sh_q);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_q       <= '0;
            fld_q       <= '0;
            sh_q        <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            edit_cap_q  <= '0;
            bcd_h_q     <= '0;
            bcd_m_q     <= '0;
            disp_q      <= '0;
            edit_disp_q <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dig_q       <= {NDIG{DIG_RESET}};
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            fld_q       <= fld_d;
            sh_q        <= sh_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            edit_cap_q  <= edit_cap_d;
            bcd_h_q     <= bcd_h_d;
            bcd_m_q     <= bcd_m_d;
            disp_q      <= disp_d;
            edit_disp_q <= edit_disp_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dig_q       <= dig_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        fld_d       = fld_q;
        sh_d        = sh_q;
        min_d       = min_q;
        sec_d       = sec_q;
        edit_cap_d  = edit_cap_q;
        bcd_h_d     = bcd_h_q;
        bcd_m_d     = bcd_m_q;
        disp_d      = disp_q;
        edit_disp_d = edit_disp_q;
        err_d       = err_q;
        done_d      = 1'b0;
        phase_d     = phase_q ^ pulse_500ms;

        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d    = S_CONV;
                    sh_d       = {8'b0, 1'b0, hours};
                    min_d      = minutes;
                    sec_d      = seconds;
                    edit_cap_d = edit_field;
                    err_d      = err_cap_c;
                    bit_d      = '0;
                    fld_d      = '0;
                end
            end
            S_CONV: begin
                sh_d  = sh_step_c;
                bit_d = bit_q + 3'd1;
                if (bit_q == LAST_BIT) begin
                    // Field finished: bank its BCD and load the next binary field
                    bit_d = '0;
                    fld_d = fld_q + 2'd1;
                    unique case (fld_q)
                        2'd0: begin
                            bcd_h_d = sh_step_c[13:6];
                            sh_d    = {8'b0, min_q};
                        end
                        2'd1: begin
                            bcd_m_d = sh_step_c[13:6];
                            sh_d    = {8'b0, sec_q};
                        end
                        default: begin
                            // Commit all six digits in the same edge as the last shift
                            disp_d = {err_q[2] ? 8'hEE : bcd_h_q,
                                      err_q[1] ? 8'hEE : bcd_m_q,
                                      err_q[0] ? 8'hEE : sh_step_c[13:6]};
                            edit_disp_d = edit_cap_q;
                            done_d      = 1'b1;
                            state_d     = S_COMMIT;
                        end
                    endcase
                end
            end
            S_COMMIT: begin
                // Holdoff cycle: busy still high so a load here is dropped
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        // Blink uses the registered phase, so a pulse shows one cycle later
        en_h_c = !(phase_q && (edit_disp_d == 2'd1));
        en_m_c = !(phase_q && (edit_disp_d == 2'd2));
        en_s_c = !(phase_q && (edit_disp_d == 2'd3));

        dig_d[5] = {en_h_c, disp_d[23:20], 1'b0};
        dig_d[4] = {en_h_c, disp_d[19:16], phase_q};
        dig_d[3] = {en_m_c, disp_d[15:12], 1'b0};
        dig_d[2] = {en_m_c, disp_d[11:8],  phase_q};
        dig_d[1] = {en_s_c, disp_d[7:4],   1'b0};
        dig_d[0] = {en_s_c, disp_d[3:0],   1'b0};
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d1   = dig_q[0];
    assign d2   = dig_q[1];
    assign d3   = dig_q[2];
    assign d4   = dig_q[3];
    assign d5   = dig_q[4];
    assign d6   = dig_q[5];
    assign d7   = 6'b000000;
    assign d8   = 6'b000000;

endmodule

// File: tb/tb_digit_bus_encoder.sv
// Testbench for digit_bus_encoder: directed loads with hand-computed digit codes.
// Honours DIGIT_RANGE_CHECK_EN for the out-of-range expectations.

module tb_digit_bus_encoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] edit_field;
    logic       pulse_500ms;
    logic       busy;
    logic       done;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;

    int n_tot = 0;
    int n_bad = 0;
    int n_done;

    digit_bus_encoder dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .edit_field  (edit_field),
        .pulse_500ms (pulse_500ms),
        .busy        (busy),
        .done        (done),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .d4          (d4),
        .d5          (d5),
        .d6          (d6),
        .d7          (d7),
        .d8          (d8)
    );

    always #5 clock = ~clock;

    function automatic logic [47:0] digs();
        return {d8, d7, d6, d5, d4, d3, d2, d1};
    endfunction

    // Expected bus from six BCD nibbles (HH MM SS), blink phase and edit field
    function automatic logic [47:0] exp_dig(input logic [23:0] nib, input logic ph,
                                            input logic [1:0] ed);
        logic eh, em, es;
        eh = !(ph && ed == 2'd1);
        em = !(ph && ed == 2'd2);
        es = !(ph && ed == 2'd3);
        return {12'b0,
                eh, nib[23:20], 1'b0, eh, nib[19:16], ph,
                em, nib[15:12], 1'b0, em, nib[11:8],  ph,
                es, nib[7:4],   1'b0, es, nib[3:0],   1'b0};
    endfunction

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a load in the current cycle; returns in cycle 1 of the conversion
    task automatic start(input int h, input int m, input int s, input int e);
        hours      = 5'(h);
        minutes    = 6'(m);
        seconds    = 6'(s);
        edit_field = 2'(e);
        load       = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    localparam logic [47:0] RESET_DIGS = 48'h000820820820;
    localparam logic [47:0] DIGS_123456 = 48'h0008A49A8AAC;

    initial begin
        reset = 1'b1; load = 1'b0; hours = '0; minutes = '0; seconds = '0;
        edit_field = '0; pulse_500ms = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_digits", digs(), RESET_DIGS);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_done", 48'(done), 48'd0);

        // 12:34:56, latency and no partial digits
        start(12, 34, 56, 0);
        chk("busy_c1", 48'(busy), 48'd1);
        repeat (17) tick();
        chk("busy_c18", 48'(busy), 48'd1);
        chk("done_c18", 48'(done), 48'd0);
        chk("nopartial_c18", digs(), RESET_DIGS);
        tick();
        chk("done_c19", 48'(done), 48'd1);
        chk("digits_123456", digs(), DIGS_123456);
        tick();
        chk("done_c20", 48'(done), 48'd0);
        chk("busy_c20", 48'(busy), 48'd0);

        // 23:59:59, second load at cycle 5 and a load in the commit cycle ignored
        start(23, 59, 59, 0);
        repeat (4) tick();
        hours = '0; minutes = '0; seconds = '0;
        load = 1'b1;
        tick();
        load = 1'b0;
        n_done = 0;
        for (int c = 6; c <= 18; c++) begin
            if (done) n_done++;
            tick();
        end
        chk("early_done", 48'(n_done), 48'd0);
        chk("done_235959", 48'(done), 48'd1);
        chk("digits_235959", digs(), exp_dig(24'h235959, 1'b0, 2'd0));
        hours = 5'd11; minutes = 6'd11; seconds = 6'd11;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("commit_load_done", 48'(done), 48'd0);
        chk("commit_load_busy", 48'(busy), 48'd0);
        repeat (25) tick();
        chk("commit_load_digits", digs(), exp_dig(24'h235959, 1'b0, 2'd0));

        // Edit minutes with two blink pulses
        start(12, 34, 56, 2);
        repeat (18) tick();
        chk("edit_ph0", digs(), DIGS_123456);
        tick();
        pulse_500ms = 1'b1;
        tick();
        pulse_500ms = 1'b0;
        chk("blink_lag", digs(), DIGS_123456);
        tick();
        chk("edit_ph1", digs(), 48'h0008A5189AAC);
        pulse_500ms = 1'b1;
        tick();
        pulse_500ms = 1'b0;
        tick();
        chk("edit_ph0_again", digs(), DIGS_123456);

        // Blink pulse during conversion still toggles phase; edit seconds
        start(12, 34, 56, 3);
        repeat (2) tick();
        pulse_500ms = 1'b1;
        tick();
        pulse_500ms = 1'b0;
        repeat (15) tick();
        chk("done_pulse_conv", 48'(done), 48'd1);
        chk("edit_sec_ph1", digs(), exp_dig(24'h123456, 1'b1, 2'd3));
        pulse_500ms = 1'b1;
        tick();
        pulse_500ms = 1'b0;
        tick();
        chk("edit_sec_ph0", digs(), DIGS_123456);

        // Reset at cycle 10 of a conversion aborts it
        start(23, 59, 59, 0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_digits", digs(), RESET_DIGS);
        chk("abort_busy", 48'(busy), 48'd0);
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) n_done++;
            tick();
        end
        chk("abort_no_done", 48'(n_done), 48'd0);
        chk("abort_digits_late", digs(), RESET_DIGS);

        // Out-of-range values
        start(25, 61, 7, 0);
        repeat (18) tick();
        chk("done_256107", 48'(done), 48'd1);
`ifdef DIGIT_RANGE_CHECK_EN
        chk("digits_256107", digs(), 48'h000F3CF3C82E);
`else
        chk("digits_256107", digs(), exp_dig(24'h256107, 1'b0, 2'd0));
`endif
        tick();

        // Largest encodable binary values
        start(31, 63, 0, 0);
        repeat (18) tick();
        chk("done_316300", 48'(done), 48'd1);
`ifdef DIGIT_RANGE_CHECK_EN
        chk("digits_316300", digs(), exp_dig(24'hEEEE00, 1'b0, 2'd0));
`else
        chk("digits_316300", digs(), exp_dig(24'h316300, 1'b0, 2'd0));
`endif
        tick();
        chk("d8_d7_blank", {36'b0, d8, d7}, 48'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
